seq_mem_responder: RTL and testbench
====================================

# seq_mem_responder

Memory-side responder for the sequence generator's word-write interface (`mem_addr`/`mem_wdata`/`mem_write`/`mem_ready`). It accepts one write per handshake into an internal word RAM and returns `mem_ready` after a programmable number of wait states. It also exposes a host readback port, a write counter and an address-error flag. It replaces the behavioural memory model in system-level simulation and acts as the scratch RAM behind the generator in the FPGA build.

## Interface
- `DEPTH`, 1024 — RAM depth in 32-bit words; power of two.
- `WAIT_STATES`, 0 — extra cycles inserted between capture and `mem_ready`; range 0..15.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `mem_write` in 1 — write request, held by the initiator until `mem_ready` is sampled high.
- `mem_addr` in 32 — byte address; word index = `mem_addr[ADDR_W+1:2]`.
- `mem_wdata` in 32 — IEEE-754 single word to store.
- `mem_ready` out 1 — one-cycle write acknowledge.
- `rd_en` in 1 — host read strobe.
- `rd_addr` in ADDR_W — host word index, ADDR_W = $clog2(DEPTH).
- `rd_data` out 32 — read data, valid the cycle after `rd_en`.
- `wr_count` out 32 — accepted writes since reset/clear.
- `cnt_clr` in 1 — synchronous clear of `wr_count` and `addr_err`.
- `addr_err` out 1 — sticky flag for a misaligned or out-of-range write (range-check build only).

## Operation
- State machine: IDLE, WAIT, ACK.
  - IDLE: on `mem_write`=1 at an edge, capture the address and data and write the RAM at that same edge.
  - After capture, go to WAIT if `WAIT_STATES`>0, otherwise go to ACK.
  - WAIT: a down-counter loaded with `WAIT_STATES`-1; go to ACK when it reaches 0. `mem_write` is ignored in WAIT.
  - ACK: `mem_ready`=1 for exactly one cycle, then return to IDLE unconditionally. `mem_write` is ignored in ACK.
- Initiator rule: after sampling `mem_ready`, the initiator presents the next request or deasserts `mem_write`. A request seen in IDLE is always a new write, so no write is ever duplicated.
- `wr_count` increments by 1 at each capture edge and wraps modulo 2^32.
- `cnt_clr` clears `wr_count` and `addr_err`. If `cnt_clr` and a capture fall on the same edge, `wr_count` becomes 1.
- Readback: a synchronous read port independent of the write FSM.
  - When a read and a capture hit the same word on the same edge, `rd_data` returns the old data (read-first).
  - `rd_data` holds its value when `rd_en`=0.
- Reset is asynchronous. It forces IDLE and clears `mem_ready`, `wr_count`, `addr_err`, `rd_data` and the wait counter to 0. RAM contents are not cleared.
- A reset asserted mid-handshake aborts the transaction: no `mem_ready` is issued. If the capture edge already occurred before reset, the RAM word stays written.

## Timing
- With `WAIT_STATES`=0, the handshake is capture at edge T and `mem_ready` high in cycle T+1. The next capture is possible at edge T+2, so peak rate is one write per 2 cycles.
- General case: `mem_ready` is high in cycle T+1+`WAIT_STATES`, and the request period is 2+`WAIT_STATES` cycles.
- Read latency is 1 cycle.
- All outputs are registered. There is no combinational path from inputs to `mem_ready`.

## Configuration
- `SEQ_MEM_RANGE_CHECK_EN` defined:
  - A capture with `mem_addr[1:0]`≠0 or word index ≥ `DEPTH` sets `addr_err`.
  - That write does not update the RAM.
  - It is still counted and still acknowledged, so the initiator never hangs.
- Undefined:
  - Low address bits are dropped and the index is truncated to ADDR_W bits (wrap-around).
  - `addr_err` is tied to 0.

## Structure
- Package `seq_mem_pkg` holds:
  - `WORD_W`=32;
  - the state enum `seq_mem_state_t` (IDLE/WAIT/ACK);
  - the byte-to-word index function.
- One sub-module, `seq_word_ram`: a simple dual-port synchronous RAM with one write port and one read-first read port, parameterised by `DEPTH`. It is inferable as block RAM.
- The top level contains the FSM, wait counter, write counter and range check.

## Test plan
- `WAIT_STATES`=0, `mem_write` held at addr 0, data 0x3F800000:
  - `mem_ready` is high exactly 1 cycle after capture;
  - `rd_addr`=0 returns 0x3F800000;
  - `wr_count`=1.
- `WAIT_STATES`=3, a back-to-back stream of 5 words starting at addr 20 (0x41200000, 0x41180000, 0x41100000, 0x41080000, 0x41000000):
  - each `mem_ready` arrives 4 cycles after its capture;
  - words 5..9 hold the data;
  - `wr_count`=5.
- Initiator holds `mem_write` for 1 extra cycle after `mem_ready`:
  - no second capture occurs;
  - `wr_count` does not increment.
- Reset asserted in WAIT (`WAIT_STATES`=5, write to addr 60):
  - `mem_ready` never pulses;
  - `wr_count`=0 after reset;
  - word 15 keeps the written data.
- With `SEQ_MEM_RANGE_CHECK_EN`, write to addr 0x1002 (misaligned) and then addr 4096 (out of range, `DEPTH`=1024):
  - both are acknowledged and `addr_err`=1;
  - words 0 and 1024-mod wrap are unchanged;
  - `cnt_clr` clears the flag.
- Same-edge read and write to word 3 (old 0xC0A00000, new 0xC0200000):
  - `rd_data`=0xC0A00000;
  - the next read returns 0xC0200000.

Source files
------------

// File: rtl/seq_mem_responder_pkg.sv
// Shared types and helpers for the sequence-generator memory responder.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
//
// Contents: WORD_W data width, seq_mem_state_t handshake FSM states,
// byte_to_word() byte-address to word-index conversion.
package seq_mem_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } seq_mem_state_t;

   // Word index of a byte address; callers truncate to their RAM depth.
   function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
      return {2'b00, byte_addr[31:2]};
   endfunction

endpackage

// File: rtl/seq_mem_responder_if.sv
// Word-write bus between the sequence generator and its memory responder.
// Latency: n/a (signal bundle only).
// Backpressure: initiator holds mem_write/addr/wdata until mem_ready is sampled high.
//
// Signals: mem_write (request), mem_addr (byte address), mem_wdata (word),
// mem_ready (one-cycle acknowledge from the responder).
interface seq_mem_responder_if;
   import seq_mem_pkg::*;

   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_ready;

   // Initiator side (sequence generator / testbench).
   modport master (
      output mem_write,
      output mem_addr,
      output mem_wdata,
      input  mem_ready
   );

   // Responder side (seq_mem_responder).
   modport slave (
      input  mem_write,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready
   );
endinterface

// File: rtl/seq_word_ram.sv
// Simple dual-port word RAM: one write port, one read-first synchronous read port.
// Latency: write lands at the edge; read data valid the cycle after re.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports: clk, rst (clears only the read register), we/waddr/wdata,
// re/raddr/rdata. rdata holds its value while re is low.
module seq_word_ram
   import seq_mem_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WORD_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WORD_W-1:0]        rdata
);

   logic [WORD_W-1:0] ram [DEPTH];

   // Array itself has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         ram[waddr] <= wdata;
      end
   end

   // Non-blocking read of the array gives read-first behaviour on a
   // same-address same-edge collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= ram[raddr];
      end
   end

endmodule

// File: rtl/seq_mem_responder.sv
// Scratch-RAM responder for the sequence generator's word-write bus, with host readback.
// Latency: write stored at capture edge; mem_ready high WAIT_STATES+1 cycles later; read 1 cycle.
// Backpressure: one outstanding write; mem_write is ignored outside IDLE until the ack completes.
//
// Ports: clk, rst (async, active-high); mem (seq_mem_responder_if.slave);
// rd_en/rd_addr/rd_data host read port; wr_count accepted writes;
// cnt_clr clears wr_count and addr_err; addr_err sticky address fault.
// Optional feature macro: SEQ_MEM_RANGE_CHECK_EN (misaligned / out-of-range
// writes are dropped and flagged; otherwise the index wraps and addr_err is 0).
module seq_mem_responder
   import seq_mem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   seq_mem_responder_if.slave       mem,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WORD_W-1:0]        rd_data,
   output logic [31:0]              wr_count,
   input  logic                     cnt_clr,
   output logic                     addr_err
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   seq_mem_state_t    state_q;
   seq_mem_state_t    state_nxt;
   logic [3:0]        wait_q;
   logic [3:0]        wait_nxt;
   logic              capture;
   logic              mem_ready_q;
   logic [31:0]       word_full;
   logic [ADDR_W-1:0] word_idx;
   logic              ram_we;

   assign word_full = byte_to_word(mem.mem_addr);
   assign word_idx  = word_full[ADDR_W-1:0];

   // Handshake FSM: next state and capture decode.
   always_comb begin
      state_nxt = state_q;
      wait_nxt  = wait_q;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem.mem_write) begin
               capture = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_nxt = WAIT;
                  wait_nxt  = WAIT_LOAD;
               end else begin
                  state_nxt = ACK;
               end
            end
         end
         WAIT: begin
            if (wait_q == 4'd0) begin
               state_nxt = ACK;
            end else begin
               wait_nxt = wait_q - 4'd1;
            end
         end
         ACK: begin
            // Request is still held during the ack cycle; never re-capture it here.
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= 4'd0;
         mem_ready_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         wait_q      <= wait_nxt;
         // Registered copy of "in ACK" keeps mem_ready off any input path.
         mem_ready_q <= (state_nxt == ACK);
      end
   end

   assign mem.mem_ready = mem_ready_q;

   // A clear coinciding with a capture still counts that capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count <= 32'd0;
      end else if (cnt_clr) begin
         wr_count <= capture ? 32'd1 : 32'd0;
      end else if (capture) begin
         wr_count <= wr_count + 32'd1;
      end
   end

`ifdef SEQ_MEM_RANGE_CHECK_EN
   logic bad_addr;

   assign bad_addr = (mem.mem_addr[1:0] != 2'b00) || (word_full >= 32'(DEPTH));
   // Faulty writes are still counted and acked, but never touch the RAM.
   assign ram_we   = capture && !bad_addr;

   // A faulty capture on the clearing edge leaves the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_err <= 1'b0;
      end else if (capture && bad_addr) begin
         addr_err <= 1'b1;
      end else if (cnt_clr) begin
         addr_err <= 1'b0;
      end
   end
`else
   // Low byte bits are dropped and the index wraps modulo DEPTH.
   logic unused_addr_bits;

   assign unused_addr_bits = ^{word_full[31:ADDR_W], mem.mem_addr[1:0]};
   assign ram_we           = capture;
   assign addr_err         = 1'b0;
`endif

   seq_word_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (word_idx),
      .wdata (mem.mem_wdata),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_seq_mem_responder.sv
// Testbench for seq_mem_responder: three instances (WAIT_STATES 0, 3, 5) on shared stimulus.
// Latency: n/a.
// Backpressure: bench initiator holds each request until mem_ready is seen.
`timescale 1ns/1ps
module tb_seq_mem_responder;
   import seq_mem_pkg::*;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              cnt_clr;
   logic [1:0]        sel;

   logic [31:0] rd_data_a  [3];
   logic [31:0] wr_count_a [3];
   logic        ready_a    [3];
   logic        addr_err_a [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance g has WAIT_STATES 0, 3, 5; only the selected one sees mem_write.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      seq_mem_responder_if bus ();

      assign bus.mem_write = mem_write && (sel == 2'(g));
      assign bus.mem_addr  = mem_addr;
      assign bus.mem_wdata = mem_wdata;
      assign ready_a[g]    = bus.mem_ready;

      seq_mem_responder #(
         .DEPTH       (DEPTH),
         .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .mem      (bus),
         .rd_en    (rd_en),
         .rd_addr  (rd_addr),
         .rd_data  (rd_data_a[g]),
         .wr_count (wr_count_a[g]),
         .cnt_clr  (cnt_clr),
         .addr_err (addr_err_a[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Call just after a negedge. Returns at the negedge where mem_ready is seen,
   // with mem_write still high; lat counts cycles after the capture edge (0 = timeout).
   task automatic do_write(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                           input logic clr, output int lat);
      sel       = s;
      mem_addr  = a;
      mem_wdata = d;
      mem_write = 1'b1;
      cnt_clr   = clr;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ready_a[s]) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_read(input logic [1:0] s, input logic [ADDR_W-1:0] a, output logic [31:0] d);
      @(negedge clk);
      rd_en   = 1'b1;
      rd_addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      d     = rd_data_a[s];
   endtask

   typedef struct {
      logic [1:0]        s;
      logic [31:0]       addr;
      logic [31:0]       data;
      logic [ADDR_W-1:0] idx;
      int                lat;
   } vec_t;

   vec_t tab [6];

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int          lat;
      int          pulses;
      logic [31:0] d;

      tab[0] = '{2'd0, 32'd0,  32'h3F80_0000, 10'd0, 1};
      tab[1] = '{2'd1, 32'd20, 32'h4120_0000, 10'd5, 4};
      tab[2] = '{2'd1, 32'd24, 32'h4118_0000, 10'd6, 4};
      tab[3] = '{2'd1, 32'd28, 32'h4110_0000, 10'd7, 4};
      tab[4] = '{2'd1, 32'd32, 32'h4108_0000, 10'd8, 4};
      tab[5] = '{2'd1, 32'd36, 32'h4100_0000, 10'd9, 4};

      rst       = 1'b1;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      cnt_clr   = 1'b0;
      sel       = 2'd0;

      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rst_ready%0d", g),    32'(ready_a[g]),    32'd0);
         check($sformatf("rst_count%0d", g),    wr_count_a[g],      32'd0);
         check($sformatf("rst_err%0d", g),      32'(addr_err_a[g]), 32'd0);
         check($sformatf("rst_rd_data%0d", g),  rd_data_a[g],       32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Vector table: WS0 single write, then WS3 back-to-back stream.
      for (int i = 0; i < 6; i++) begin
         do_write(tab[i].s, tab[i].addr, tab[i].data, 1'b0, lat);
         check($sformatf("lat%0d", i), 32'(lat), 32'(tab[i].lat));
         if (i == 5 || tab[i + 1].s != tab[i].s) mem_write = 1'b0;
         @(negedge clk);
      end
      for (int i = 0; i < 6; i++) begin
         do_read(tab[i].s, tab[i].idx, d);
         check($sformatf("word%0d", tab[i].idx), d, tab[i].data);
      end
      check("count_ws0", wr_count_a[0], 32'd1);
      check("count_ws3", wr_count_a[1], 32'd5);

      // Request held across the ack edge: must not be captured twice.
      @(negedge clk);
      do_write(2'd0, 32'd8, 32'h4040_0000, 1'b0, lat);
      check("hold_lat", 32'(lat), 32'd1);
      @(posedge clk);
      #1 mem_write = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready_a[0]) pulses++;
      end
      check("hold_pulses", 32'(pulses), 32'd0);
      check("hold_count", wr_count_a[0], 32'd2);

      // Clear on the capture edge leaves the count at 1.
      @(negedge clk);
      do_write(2'd0, 32'd12, 32'h4080_0000, 1'b1, lat);
      check("clr_capture_count", wr_count_a[0], 32'd1);
      mem_write = 1'b0;

      // Same-edge read and write to word 3: read-first, then hold, then new data.
      @(negedge clk);
      do_write(2'd0, 32'd12, 32'hC0A0_0000, 1'b0, lat);
      mem_write = 1'b0;
      @(negedge clk);
      sel       = 2'd0;
      rd_en     = 1'b1;
      rd_addr   = 10'd3;
      mem_addr  = 32'd12;
      mem_wdata = 32'hC020_0000;
      mem_write = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      @(negedge clk);
      check("rf_old", rd_data_a[0], 32'hC0A0_0000);
      mem_write = 1'b0;
      @(negedge clk);
      check("rd_hold", rd_data_a[0], 32'hC0A0_0000);
      do_read(2'd0, 10'd3, d);
      check("rf_new", d, 32'hC020_0000);

      // Reset during WAIT on the WS5 instance.
      @(negedge clk);
      sel       = 2'd2;
      mem_addr  = 32'd60;
      mem_wdata = 32'h4270_0000;
      mem_write = 1'b1;
      @(posedge clk);
      #1 mem_write = 1'b0;
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (ready_a[2]) pulses++;
         if (i == 1) rst = 1'b1;
         if (i == 4) rst = 1'b0;
      end
      check("rstwait_pulses", 32'(pulses), 32'd0);
      check("rstwait_count", wr_count_a[2], 32'd0);
      do_read(2'd2, 10'd15, d);
      check("rstwait_word15", d, 32'h4270_0000);

      // Misaligned and out-of-range writes on the WS0 instance.
      @(negedge clk);
      do_write(2'd0, 32'd0, 32'h1111_1111, 1'b1, lat);
      mem_write = 1'b0;
      @(negedge clk);
      do_write(2'd0, 32'h0000_1002, 32'hAAAA_0000, 1'b0, lat);
      check("mis_lat", 32'(lat), 32'd1);
      mem_write = 1'b0;
      @(negedge clk);
      do_write(2'd0, 32'h0000_1000, 32'hBBBB_0000, 1'b0, lat);
      check("oor_lat", 32'(lat), 32'd1);
      mem_write = 1'b0;
      @(negedge clk);
      check("range_count", wr_count_a[0], 32'd3);
      do_read(2'd0, 10'd0, d);
`ifdef SEQ_MEM_RANGE_CHECK_EN
      check("range_err", 32'(addr_err_a[0]), 32'd1);
      check("range_word0", d, 32'h1111_1111);
`else
      check("range_err", 32'(addr_err_a[0]), 32'd0);
      check("range_word0", d, 32'hBBBB_0000);
`endif
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("clr_err", 32'(addr_err_a[0]), 32'd0);
      check("clr_count", wr_count_a[0], 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
